// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Covers the loader state encoding, the default frame sync byte and the instruction word width.
package cpu_defs;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         INSN_WIDTH        = 32;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs incoming bytes MSB-first into 32-bit words and keeps a running XOR checksum.
// word_next already contains the current byte, so the loader can capture a finished word on the edge that accepts its 4th byte.
module boot_word_assembler
    import cpu_defs::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic [INSN_WIDTH-1:0] word_next,
    output logic [7:0]            csum,
    output logic                  word_ready
);

    logic [INSN_WIDTH-9:0] shift_q, shift_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [7:0]            csum_q, csum_d;

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        word_next  = {shift_q, byte_in};
        word_ready = byte_valid && (cnt_q == 2'd3);
        if (clear) begin
            shift_d = '0;
            cnt_d   = 2'd0;
            csum_d  = 8'h00;
        end else if (byte_valid) begin
            shift_d = word_next[INSN_WIDTH-9:0];
            cnt_d   = cnt_q + 2'd1;
            csum_d  = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
            csum_q  <= 8'h00;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    assign csum = csum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image (sync, length, data, checksum), writes it into instruction memory,
// and holds the CPU until a load finishes with a matching checksum.
module imem_boot_loader
    import cpu_defs::*;
#(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [31:0]           IAddr,
    output logic [INSN_WIDTH-1:0] IDataIn,
    output logic                  imem_wr,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           words_loaded
);

    state_t                state_q, state_d;
    logic                  rx_ready_q, rx_ready_d;
    logic [31:0]           iaddr_q, iaddr_d;
    logic [INSN_WIDTH-1:0] idata_q, idata_d;
    logic                  imem_wr_q, imem_wr_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic [15:0]           words_loaded_q, words_loaded_d;
    logic [15:0]           len_q, len_d;

    logic                  accept;
    logic                  start_frame;
    logic                  asm_clear;
    logic                  asm_valid;
    logic [INSN_WIDTH-1:0] asm_word;
    logic [7:0]            asm_csum;
    logic                  asm_word_ready;
    logic [15:0]           len_next;

    assign accept    = rx_valid && rx_ready_q;
    assign asm_valid = accept && (state_q == DATA);
    assign len_next  = {len_q[15:8], rx_data};

    boot_word_assembler u_assembler (
        .clk        (CLK),
        .rst_n      (Reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_data),
        .word_next  (asm_word),
        .csum       (asm_csum),
        .word_ready (asm_word_ready)
    );

    always_comb begin
        state_d        = state_q;
        rx_ready_d     = 1'b1;
        iaddr_d        = iaddr_q;
        idata_d        = idata_q;
        imem_wr_d      = 1'b0;
        cpu_hold_d     = cpu_hold_q;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;
        len_d          = len_q;
        start_frame    = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (accept && rx_data == SYNC_BYTE) start_frame = 1'b1;
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = len_next;
                    if (len_next == 16'd0 || len_next > 16'(MAX_WORDS)) begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Stall the receiver for the write cycle so the word is committed before the next byte.
                if (asm_word_ready) begin
                    state_d        = WRITE;
                    imem_wr_d      = 1'b1;
                    idata_d        = asm_word;
                    iaddr_d        = BASE_ADDR + 32'({words_loaded_q, 2'b00});
                    words_loaded_d = words_loaded_q + 16'd1;
                    rx_ready_d     = 1'b0;
                end
            end
            WRITE: begin
                state_d = (words_loaded_q == len_q) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == asm_csum) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d        = LEN_HI;
            iaddr_d        = BASE_ADDR;
            words_loaded_d = 16'd0;
            cpu_hold_d     = 1'b1;
            load_done_d    = 1'b0;
            load_err_d     = 1'b0;
        end
        asm_clear = start_frame;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q        <= IDLE;
            rx_ready_q     <= 1'b1;
            iaddr_q        <= BASE_ADDR;
            idata_q        <= '0;
            imem_wr_q      <= 1'b0;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= 16'd0;
            len_q          <= 16'd0;
        end else begin
            state_q        <= state_d;
            rx_ready_q     <= rx_ready_d;
            iaddr_q        <= iaddr_d;
            idata_q        <= idata_d;
            imem_wr_q      <= imem_wr_d;
            cpu_hold_q     <= cpu_hold_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
            len_q          <= len_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign IAddr        = iaddr_q;
    assign IDataIn      = idata_q;
    assign imem_wr      = imem_wr_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule
